// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronizer plus four-state debouncer with saturating glitch counter
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   signal_in    raw asynchronous, possibly bouncing level
//   glitch_clr   synchronous clear of glitch_count (wins over a same-edge glitch)
//   signal_out   registered debounced level (1 in HIGH and WAIT_LOW)
//   busy         registered, 1 while a candidate transition is being qualified
//   glitch_count registered saturating count of aborted qualifications
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signal_in,
    input  logic                glitch_clr,
    output logic                signal_out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_count
);

    // Counter holds values up to DEBOUNCE_CYCLES inclusive, so it never wraps.
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state, state_next;
    logic [CW-1:0]          cnt, cnt_next, cnt_inc;
    logic                   glitch_hit;

    // Synchronizer chain; only its last stage is visible to the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        cnt_inc    = cnt + CW'(1);
        glitch_hit = 1'b0;
        case (state)
            LOW: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = HIGH;
                    end else begin
                        state_next = WAIT_HIGH;
                        cnt_next   = CW'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (s) begin
                    if (cnt_inc == CNT_DONE) begin
                        state_next = HIGH;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    state_next = LOW;
                    glitch_hit = 1'b1;
                end
            end
            HIGH: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = LOW;
                    end else begin
                        state_next = WAIT_LOW;
                        cnt_next   = CW'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (!s) begin
                    if (cnt_inc == CNT_DONE) begin
                        state_next = LOW;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    state_next = HIGH;
                    glitch_hit = 1'b1;
                end
            end
            default: begin
                state_next = LOW;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOW;
            cnt        <= '0;
            signal_out <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            signal_out <= (state_next == HIGH) || (state_next == WAIT_LOW);
            busy       <= (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || glitch_clr) begin
            glitch_count <= '0;
        end else if (glitch_hit && (glitch_count != {GLITCH_W{1'b1}})) begin
            glitch_count <= glitch_count + GLITCH_W'(1);
        end
    end

endmodule
